// File: rtl/triangle_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | triangle_feeder_pkg                                                  |
// | Shared FSM encodings and default widths for the triangle feeder.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package triangle_feeder_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    localparam int unsigned c_DEF_COORD_W  = 16;
    localparam int unsigned c_DEF_COLOUR_W = 3;

endpackage : triangle_feeder_pkg
`default_nettype wire

// File: rtl/tri_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tri_fifo                                                             |
// | Register FIFO of packed triangles; flush may retain the head entry.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tri_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 99
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic                     i_keep_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            // An in-flight head survives unless it is retired in this same cycle.
            if (i_keep_head && !w_pop) begin
                r_wr_ptr <= r_rd_ptr + PTR_W'(1);
                r_count  <= CNT_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
                r_wr_ptr <= r_rd_ptr + PTR_W'(w_pop);
                r_count  <= '0;
            end
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !i_flush)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule : tri_fifo
`default_nettype wire

// File: rtl/triangle_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | triangle_feeder                                                      |
// | Queues triangles and issues them one at a time to draw_triangle.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module triangle_feeder
    import triangle_feeder_pkg::*;
#(
    parameter int          COORD_W  = c_DEF_COORD_W,
    parameter int          COLOUR_W = c_DEF_COLOUR_W,
    parameter int          DEPTH    = 4,
    parameter int unsigned TIMEOUT  = 2**20
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [COORD_W-1:0]      in_ax,
    input  logic [COORD_W-1:0]      in_ay,
    input  logic [COORD_W-1:0]      in_bx,
    input  logic [COORD_W-1:0]      in_by,
    input  logic [COORD_W-1:0]      in_cx,
    input  logic [COORD_W-1:0]      in_cy,
    input  logic [COLOUR_W-1:0]     in_colour,
    output logic [COORD_W-1:0]      ax,
    output logic [COORD_W-1:0]      ay,
    output logic [COORD_W-1:0]      bx,
    output logic [COORD_W-1:0]      by,
    output logic [COORD_W-1:0]      cx,
    output logic [COORD_W-1:0]      cy,
    output logic [COLOUR_W-1:0]     colour,
    output logic                    draw_en,
    input  logic                    screen_done,
    input  logic                    flush,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    timeout_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WIDTH = 6 * COORD_W + COLOUR_W;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] c_WD_LIMIT = WD_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WD_W-1:0]  r_wdog;
    logic [WIDTH-1:0] r_tri;
    logic [WIDTH-1:0] w_head;
    logic             r_timeout_err;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_abort;
    logic             w_expired;

    assign in_ready  = resetn && (count < CNT_W'(DEPTH)) && !flush;
    assign w_push    = in_valid && in_ready;
    assign w_expired = (r_wdog == c_WD_LIMIT);

    tri_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clock       (clock),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_wr_data   ({in_ax, in_ay, in_bx, in_by, in_cx, in_cy, in_colour}),
        .i_pop       (w_pop),
        .i_flush     (flush),
        .i_keep_head (busy),
        .o_count     (count),
        .o_head      (w_head)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if ((count != '0) && !flush) w_next = c_ST_ISSUE;
            c_ST_ISSUE: w_next = c_ST_WAIT;
            c_ST_WAIT:  if (screen_done || w_expired) w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        draw_en = (r_state == c_ST_ISSUE);
        busy    = (r_state != c_ST_IDLE);
        w_load  = (r_state == c_ST_IDLE) && (count != '0) && !flush;
        w_pop   = (r_state == c_ST_WAIT) && (screen_done || w_expired);
        w_abort = (r_state == c_ST_WAIT) && !screen_done && w_expired;
    end

    // Watchdog saturates so a long WAIT can never wrap back below the limit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_wdog <= '0;
        else if (r_state == c_ST_ISSUE)
            r_wdog <= '0;
        else if ((r_state == c_ST_WAIT) && (r_wdog != {WD_W{1'b1}}))
            r_wdog <= r_wdog + WD_W'(1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tri         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_load)
                r_tri <= w_head;
            if (w_abort)
                r_timeout_err <= 1'b1;
        end
    end

    assign {ax, ay, bx, by, cx, cy, colour} = r_tri;
    assign timeout_err = r_timeout_err;

endmodule : triangle_feeder
`default_nettype wire
